// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int DEPTH_DEF  = 64;

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word assembler: little-endian byte lanes, one-cycle word-valid pulse.
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        wvalid,
    output logic        last
);

    logic [1:0] bcnt;

    assign last = (bcnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            bcnt   <= '0;
            word   <= '0;
            wvalid <= 1'b0;
        end else begin
            wvalid <= en && last && !clr;
            if (clr) begin
                bcnt <= '0;
            end else if (en) begin
                word[{bcnt, 3'b000} +: 8] <= data;
                bcnt                      <= bcnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the
// processor in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       cnt;
    logic [15:0]       hdr;
    logic              xfer;
    logic              restart;
    logic              last_word;
    logic              pk_last;
    logic              pk_wvalid;
    logic [31:0]       pk_word;

    assign in_ready  = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign xfer      = in_valid && in_ready;
    assign restart   = start && ((state == DONE) || (state == ERROR));
    assign hdr       = {in_data, cnt[7:0]};
    assign last_word = (16'(idx) == cnt - 16'd1);

    byte_word_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clr    (restart),
        .en     (xfer && (state == DATA)),
        .data   (in_data),
        .word   (pk_word),
        .wvalid (pk_wvalid),
        .last   (pk_last)
    );

    assign mem_we    = pk_wvalid;
    assign mem_addr  = idx;
    assign mem_wdata = pk_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HDR0;
            idx       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            // the final write lands in DONE, so the index stops at N-1
            if (pk_wvalid && (state == DATA)) begin
                idx <= idx + 1'b1;
            end
            unique case (state)
                HDR0: begin
                    if (xfer) begin
                        cnt[7:0] <= in_data;
                        state    <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        cnt[15:8] <= in_data;
                        if (hdr == 16'd0) begin
                            state <= DONE;
                        end else if (hdr > 16'(DEPTH)) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer && pk_last && last_word) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state     <= HDR0;
                        idx       <= '0;
                        cnt       <= '0;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                    end else begin
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state <= HDR0;
                        idx   <= '0;
                        cnt   <= '0;
                        error <= 1'b0;
                    end
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-format reference model.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wq[$];
    wr_t        eq[$];
    logic [7:0] sq[$];
    int         nerr = 0;
    int         nchk = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_t w;
            w.addr = int'(mem_addr);
            w.data = mem_wdata;
            wq.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected writes derived only from the stream format.
    function automatic void build_exp();
        int  n;
        wr_t w;
        eq.delete();
        n = int'({sq[1], sq[0]});
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w.addr = i;
                w.data = {sq[2+4*i+3], sq[2+4*i+2], sq[2+4*i+1], sq[2+4*i]};
                eq.push_back(w);
            end
        end
    endfunction

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            chk({tag, "_addr"}, wq[i].addr, eq[i].addr);
            chk({tag, "_data"}, wq[i].data, eq[i].data);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rnd, input int lim,
                        output bit acc);
        int t = 0;
        acc = 1'b0;
        while (!acc && t < lim) begin
            @(negedge clk);
            in_data  = b;
            in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            acc      = in_valid && in_ready;
            @(posedge clk);
            t++;
        end
    endtask

    task automatic load_bytes(input int first, input int count, input bit rnd);
        bit a;
        int nacc = 0;
        for (int i = first; i < first + count; i++) begin
            send(sq[i], rnd, 100, a);
            nacc += int'(a);
        end
        chk("accepted", nacc, count);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        if (check) begin
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_cpu_reset", cpu_reset, 1);
            chk("rst_in_ready", in_ready, 1);
        end
        reset = 1'b1;
        wq.delete();
    endtask

    initial begin
        bit a;
        int nacc;

        // power-on reset with output checks
        do_reset(1'b1);
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_cpu_reset", cpu_reset, 1);

        // two-word load, continuous valid
        sq = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        build_exp();
        load_bytes(0, sq.size(), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_last_we", mem_we, 1);
        chk("t1_last_addr", mem_addr, 1);
        chk("t1_last_data", mem_wdata, 32'hdeadbeef);
        chk("t1_done_early", done, 0);
        chk("t1_ready_done", in_ready, 0);
        chk("t1_cpu_rst_early", cpu_reset, 1);
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_cpu_reset", cpu_reset, 0);
        chk("t1_we_off", mem_we, 0);
        cmp_writes("t1");

        // empty program
        do_reset(1'b0);
        sq = {8'h00, 8'h00};
        build_exp();
        load_bytes(0, 2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_done_t1", done, 0);
        @(negedge clk);
        chk("t2_done_t2", done, 1);
        idle(3);
        cmp_writes("t2");

        // oversize header
        do_reset(1'b0);
        sq = {8'h41, 8'h00};
        build_exp();
        load_bytes(0, 2, 1'b0);
        idle(2);
        chk("t3_error", error, 1);
        chk("t3_cpu_reset", cpu_reset, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_done", done, 0);
        send(8'h55, 1'b0, 3, a);
        chk("t3_extra_acc", a, 0);
        idle(2);
        cmp_writes("t3");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_restart_ready", in_ready, 1);
        chk("t3_restart_error", error, 0);

        // full-depth load restarted from ERROR, plus trailing bytes
        wq.delete();
        sq = {8'h40, 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) sq.push_back(8'($urandom));
        build_exp();
        load_bytes(0, sq.size(), 1'b0);
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 1'b0, 2, a);
            nacc += int'(a);
        end
        idle(3);
        chk("t4_extra_acc", nacc, 0);
        chk("t4_done", done, 1);
        chk("t4_last_addr", wq.size() > 0 ? wq[wq.size()-1].addr : -1,
            DEPTH - 1);
        cmp_writes("t4");

        // three words with random valid gaps
        do_reset(1'b0);
        sq = {8'h03, 8'h00};
        for (int i = 0; i < 12; i++) sq.push_back(8'($urandom));
        build_exp();
        load_bytes(0, sq.size(), 1'b1);
        idle(3);
        chk("t5_done", done, 1);
        cmp_writes("t5");

        // start ignored mid-load, then reset abort after two words
        do_reset(1'b0);
        sq = {8'h03, 8'h00};
        for (int i = 0; i < 12; i++) sq.push_back(8'($urandom));
        build_exp();
        load_bytes(0, 6, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_bytes(6, 4, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        start    = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_cpu_reset", cpu_reset, 1);
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        idle(4);
        chk("t6_abort_nwr", wq.size(), 2);
        void'(eq.pop_back());
        cmp_writes("t6");
        wq.delete();
        sq = {8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        build_exp();
        load_bytes(0, sq.size(), 1'b0);
        idle(3);
        chk("t6_done", done, 1);
        cmp_writes("t6r");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, is the instruction memory depth in words.
REQ-002 Parameter ADDR_W, default 6, is the word-address width and SHALL equal clog2(DEPTH).
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 start  input  1  is a one-cycle pulse that restarts loading from DONE or ERROR.
REQ-006 in_valid  input  1  marks a valid byte on in_data.
REQ-007 in_data  input  8  carries the stream byte.
REQ-008 in_ready  output  1  means the loader accepts a byte this cycle.
REQ-009 mem_we  output  1  is a one-cycle write strobe to the instruction memory.
REQ-010 mem_addr  output  ADDR_W  is the word address being written.
REQ-011 mem_wdata  output  32  is the instruction word being written.
REQ-012 cpu_reset  output  1  is the active-high processor reset, held until loading completes.
REQ-013 done  output  1  means the program was loaded successfully.
REQ-014 error  output  1  means the header word count exceeded DEPTH.

Function
REQ-015 A byte SHALL be transferred only in a cycle where in_valid and in_ready are both 1.
REQ-016 Stream format SHALL be: a 16-bit little-endian word count N (two bytes), then N 32-bit little-endian words.
REQ-017 FSM states SHALL be HDR0, HDR1, DATA, DONE and ERROR.
REQ-018 HDR0 SHALL capture the count low byte on transfer and move to HDR1.
REQ-019 HDR1 SHALL capture the count high byte on transfer and then:
- N==0: go to DONE.
- N>DEPTH: go to ERROR.
- otherwise: go to DATA.
REQ-020 in_ready SHALL be 1 in HDR0, HDR1 and DATA, and 0 in DONE and ERROR.
REQ-021 In DATA, a 2-bit byte counter SHALL place byte k at bits [8k+7:8k] of the assembly register.
REQ-022 When byte 3 is transferred in the cycle T, mem_we SHALL be 1 in cycle T+1, with mem_wdata holding the assembled word and mem_addr holding the word index; the index SHALL then increment.
REQ-023 in_ready SHALL stay 1 during the write cycle, so a byte can be accepted back-to-back with no bubble.
REQ-024 The first word SHALL be written at address 0, and word i SHALL be written at address i.
REQ-025 After the Nth word is transferred in cycle T, the FSM SHALL enter DONE at T+1, concurrently with the final mem_we.
REQ-026 done and cpu_reset=0 SHALL become visible at T+2.
REQ-027 cpu_reset SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-028 When N==DEPTH, the last write SHALL go to address DEPTH-1, and the address counter SHALL NOT wrap into a further write.
REQ-029 Extra bytes arriving in DONE or ERROR SHALL be ignored, since in_ready is 0 in those states.
REQ-030 In DONE or ERROR, a start pulse SHALL clear the word index, byte counter and count, and go to HDR0.
REQ-031 In HDR0, HDR1 and DATA, start SHALL be ignored.
REQ-032 in_valid with in_ready=0 SHALL cause no state change.

Reset
REQ-033 On a clk edge with reset==0, the FSM SHALL go to HDR0, and the word index, byte counter, assembly register and count SHALL all clear to 0.
REQ-034 Outputs during and immediately after reset SHALL be:
- mem_we=0, mem_addr=0, mem_wdata=0.
- done=0, error=0.
- cpu_reset=1, in_ready=1.
REQ-035 Reset asserted mid-load SHALL abort the load, and no further mem_we SHALL occur until a new load begins.
REQ-036 Reset SHALL take priority over start and over any byte transfer in the same cycle.

Structure
REQ-037 A shared package SHALL hold the state encoding, the stream-format constants (header length 2 bytes, word length 4 bytes) and the DEPTH default.
REQ-038 The byte-to-word assembler (byte counter, assembly register, word-valid pulse) SHALL be one sub-module named byte_word_packer; the FSM, index and outputs SHALL stay in imem_loader.

Verification
REQ-039 Bench SHALL drive reset=0 for 2 cycles, release it, then stream 02 00 | 78 56 34 12 | EF BE AD DE with in_valid continuous; required response: writes addr0=12345678 and addr1=deadbeef, then done=1 and cpu_reset=0.
REQ-040 Bench SHALL send header 00 00; required response: DONE two cycles after the second header byte, with no mem_we ever.
REQ-041 Bench SHALL send header 41 00 (N=65, DEPTH=64); required response: error=1, cpu_reset=1, in_ready=0, and no writes.
REQ-042 Bench SHALL send header 40 00 followed by 64 words plus 4 extra bytes; required response: the last write is at addr 63, the extra bytes are not accepted, and done=1.
REQ-043 Bench SHALL toggle in_valid randomly during a 3-word load; required response: the writes are identical to those of the continuous-valid case.
REQ-044 Bench SHALL assert reset after 2 of 3 words, then reload 01 00 | 01 00 00 00; required response: a single write of addr0=00000001, then done=1.
